// File: rtl/hero_move.sv
// Hero movement controller: collision scan, key-driven tile moves on a 60-px grid, step pacing.
// Optional macro HERO_WRAP_EN lets horizontal moves at the edges teleport to the opposite limit.
module hero_move #(
  parameter logic [11:0] START_X  = 12'd482,
  parameter logic [11:0] START_Y  = 12'd648,
  parameter logic [15:0] STEP_DIV = 16'd50000,
  parameter logic [7:0]  SCAN_LEN = 8'd150,
  parameter logic [11:0] X_MIN    = 12'd62,
  parameter logic [11:0] X_MAX    = 12'd902,
  parameter logic [11:0] Y_MIN    = 12'd108,
  parameter logic [11:0] Y_MAX    = 12'd648
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_up,
  input  logic        key_down,
  input  logic [3:0]  collision,
  output logic [11:0] hero_x_pos,
  output logic [11:0] hero_y_pos,
  output logic        moving,
  output logic [1:0]  dir
);

`ifdef HERO_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {SCAN = 2'd0, IDLE = 2'd1, MOVE = 2'd2} state_t;

  state_t      state_r;
  logic [3:0]  blocked_r;
  logic [15:0] div_r;
  logic [5:0]  pix_r;
  logic [7:0]  scan_r;

  logic        any_key_s;
  logic [1:0]  sel_dir_s;
  logic        move_ok_s;
  logic        wrap_s;
  logic [11:0] wrap_x_s;
  logic [3:0]  col_s;

  // Key priority: left > right > up > down
  always_comb begin
    any_key_s = key_left | key_right | key_up | key_down;
    sel_dir_s = 2'd0;
    if (key_left) begin
      sel_dir_s = 2'd0;
    end else if (key_right) begin
      sel_dir_s = 2'd1;
    end else if (key_up) begin
      sel_dir_s = 2'd2;
    end else if (key_down) begin
      sel_dir_s = 2'd3;
    end else begin
      sel_dir_s = 2'd0;
    end
  end

  // Move legality against blocked directions and grid limits; wrap only horizontally
  always_comb begin
    move_ok_s = 1'b0;
    wrap_s    = 1'b0;
    wrap_x_s  = hero_x_pos;
    case (sel_dir_s)
      2'd0: begin
        move_ok_s = !blocked_r[0] && (hero_x_pos > X_MIN);
        wrap_s    = WRAP_EN && !blocked_r[0] && (hero_x_pos <= X_MIN);
        wrap_x_s  = X_MAX;
      end
      2'd1: begin
        move_ok_s = !blocked_r[1] && (hero_x_pos < X_MAX);
        wrap_s    = WRAP_EN && !blocked_r[1] && (hero_x_pos >= X_MAX);
        wrap_x_s  = X_MIN;
      end
      2'd2: move_ok_s = !blocked_r[2] && (hero_y_pos > Y_MIN);
      2'd3: move_ok_s = !blocked_r[3] && (hero_y_pos < Y_MAX);
      default: move_ok_s = 1'b0;
    endcase
  end

  // Collision code to blocked-bit mask; unknown codes mean no collision
  always_comb begin
    case (collision)
      4'd1:    col_s = 4'b0001;
      4'd2:    col_s = 4'b0010;
      4'd3:    col_s = 4'b0100;
      4'd4:    col_s = 4'b1000;
      default: col_s = 4'b0000;
    endcase
  end

  // Main FSM with registered position, moving and dir
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= SCAN;
      hero_x_pos <= START_X;
      hero_y_pos <= START_Y;
      moving     <= 1'b0;
      dir        <= 2'd0;
      blocked_r  <= 4'd0;
      div_r      <= 16'd0;
      pix_r      <= 6'd0;
      scan_r     <= 8'd0;
    end else begin
      case (state_r)
        SCAN: begin
          blocked_r <= blocked_r | col_s;
          if (scan_r == SCAN_LEN - 8'd1) begin
            scan_r  <= 8'd0;
            state_r <= IDLE;
          end else begin
            scan_r <= scan_r + 8'd1;
          end
        end
        IDLE: begin
          if (any_key_s) begin
            dir <= sel_dir_s;
            if (wrap_s) begin
              // Teleport completes the tile at once, so rescan at the new spot
              hero_x_pos <= wrap_x_s;
              state_r    <= SCAN;
              blocked_r  <= 4'd0;
              scan_r     <= 8'd0;
            end else if (move_ok_s) begin
              state_r <= MOVE;
              moving  <= 1'b1;
              div_r   <= 16'd0;
              pix_r   <= 6'd0;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MOVE: begin
          if (div_r == STEP_DIV - 16'd1) begin
            div_r <= 16'd0;
            case (dir)
              2'd0:    hero_x_pos <= hero_x_pos - 12'd1;
              2'd1:    hero_x_pos <= hero_x_pos + 12'd1;
              2'd2:    hero_y_pos <= hero_y_pos - 12'd1;
              2'd3:    hero_y_pos <= hero_y_pos + 12'd1;
              default: hero_x_pos <= hero_x_pos;
            endcase
            if (pix_r == 6'd59) begin
              pix_r     <= 6'd0;
              state_r   <= SCAN;
              moving    <= 1'b0;
              blocked_r <= 4'd0;
              scan_r    <= 8'd0;
            end else begin
              pix_r <= pix_r + 6'd1;
            end
          end else begin
            div_r <= div_r + 16'd1;
          end
        end
        default: begin
          state_r <= SCAN;
          moving  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hero_move.sv
// Directed bench for hero_move with STEP_DIV=2, SCAN_LEN=150.
module tb_hero_move;

  logic        clk;
  logic        rst;
  logic        key_left, key_right, key_up, key_down;
  logic [3:0]  collision;
  logic [11:0] hero_x_pos, hero_y_pos;
  logic        moving;
  logic [1:0]  dir;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  hero_move #(.STEP_DIV(16'd2), .SCAN_LEN(8'd150)) dut (
    .clk(clk), .rst(rst),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .collision(collision),
    .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos),
    .moving(moving), .dir(dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for two edges with idle inputs; caller sets keys and releases
  task automatic hold_reset();
    rst = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    collision = 4'd0;
    tick(2);
  endtask

  task automatic test_reset();
    hold_reset();
    chk_cnt++; if (hero_x_pos !== 12'd482) $display("FAIL rst_x: got %0d expected 482", hero_x_pos); else pass_cnt++;
    chk_cnt++; if (hero_y_pos !== 12'd648) $display("FAIL rst_y: got %0d expected 648", hero_y_pos); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL rst_moving: got %0b expected 0", moving); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL rst_dir: got %0d expected 0", dir); else pass_cnt++;
  endtask

  task automatic test_move_up();
    hold_reset();
    key_up = 1'b1;
    rst = 1'b1;
    tick(150);
    chk_cnt++; if (moving !== 1'b0) $display("FAIL scan_no_move: got %0b expected 0", moving); else pass_cnt++;
    tick(1);
    chk_cnt++; if (moving !== 1'b1) $display("FAIL move_start: got %0b expected 1", moving); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd2) $display("FAIL move_dir: got %0d expected 2", dir); else pass_cnt++;
    tick(1);
    chk_cnt++; if (hero_y_pos !== 12'd648) $display("FAIL y_before_step: got %0d expected 648", hero_y_pos); else pass_cnt++;
    tick(1);
    chk_cnt++; if (hero_y_pos !== 12'd647) $display("FAIL y_first_step: got %0d expected 647", hero_y_pos); else pass_cnt++;
    tick(118);
    chk_cnt++; if (hero_y_pos !== 12'd588) $display("FAIL y_tile_done: got %0d expected 588", hero_y_pos); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL tile_done_moving: got %0b expected 0", moving); else pass_cnt++;
    tick(1);
    chk_cnt++; if (moving !== 1'b0) $display("FAIL rescan_ignores_key: got %0b expected 0", moving); else pass_cnt++;
    tick(149);
    chk_cnt++; if (moving !== 1'b0) $display("FAIL rescan_len: got %0b expected 0", moving); else pass_cnt++;
    tick(1);
    chk_cnt++; if (moving !== 1'b1) $display("FAIL second_move_start: got %0b expected 1", moving); else pass_cnt++;
    tick(2);
    chk_cnt++; if (hero_y_pos !== 12'd587) $display("FAIL second_step: got %0d expected 587", hero_y_pos); else pass_cnt++;
    // Asynchronous reset mid-move, checked before any further edge
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if (hero_x_pos !== 12'd482) $display("FAIL mid_rst_x: got %0d expected 482", hero_x_pos); else pass_cnt++;
    chk_cnt++; if (hero_y_pos !== 12'd648) $display("FAIL mid_rst_y: got %0d expected 648", hero_y_pos); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL mid_rst_moving: got %0b expected 0", moving); else pass_cnt++;
    chk_cnt++; if (dir !== 2'd0) $display("FAIL mid_rst_dir: got %0d expected 0", dir); else pass_cnt++;
  endtask

  task automatic test_blocked_up();
    hold_reset();
    rst = 1'b1;
    tick(10);
    collision = 4'd3;
    tick(1);
    collision = 4'd0;
    tick(139);
    key_up = 1'b1;
    tick(1);
    chk_cnt++; if (dir !== 2'd2) $display("FAIL blocked_dir: got %0d expected 2", dir); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL blocked_moving: got %0b expected 0", moving); else pass_cnt++;
    tick(5);
    chk_cnt++; if (hero_y_pos !== 12'd648) $display("FAIL blocked_y: got %0d expected 648", hero_y_pos); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL blocked_hold: got %0b expected 0", moving); else pass_cnt++;
  endtask

  task automatic test_down_limit();
    hold_reset();
    key_down = 1'b1;
    rst = 1'b1;
    tick(151);
    chk_cnt++; if (dir !== 2'd3) $display("FAIL down_dir: got %0d expected 3", dir); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL down_moving: got %0b expected 0", moving); else pass_cnt++;
    tick(3);
    chk_cnt++; if (hero_y_pos !== 12'd648) $display("FAIL down_y: got %0d expected 648", hero_y_pos); else pass_cnt++;
    chk_cnt++; if (hero_x_pos !== 12'd482) $display("FAIL down_x: got %0d expected 482", hero_x_pos); else pass_cnt++;
  endtask

  task automatic test_priority_left();
    hold_reset();
    key_left = 1'b1;
    key_up = 1'b1;
    rst = 1'b1;
    tick(151);
    chk_cnt++; if (dir !== 2'd0) $display("FAIL prio_dir: got %0d expected 0", dir); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b1) $display("FAIL prio_moving: got %0b expected 1", moving); else pass_cnt++;
    tick(120);
    chk_cnt++; if (hero_x_pos !== 12'd422) $display("FAIL prio_x: got %0d expected 422", hero_x_pos); else pass_cnt++;
    chk_cnt++; if (hero_y_pos !== 12'd648) $display("FAIL prio_y: got %0d expected 648", hero_y_pos); else pass_cnt++;
  endtask

  // Seven left tiles reach X_MIN; the eighth request wraps or is refused
  task automatic test_left_edge();
    hold_reset();
    key_left = 1'b1;
    rst = 1'b1;
    tick(2047);
    chk_cnt++; if (hero_x_pos !== 12'd62) $display("FAIL edge_x_min: got %0d expected 62", hero_x_pos); else pass_cnt++;
    chk_cnt++; if (moving !== 1'b0) $display("FAIL edge_idle: got %0b expected 0", moving); else pass_cnt++;
    tick(1);
`ifdef HERO_WRAP_EN
    chk_cnt++; if (hero_x_pos !== 12'd902) $display("FAIL edge_wrap_x: got %0d expected 902", hero_x_pos); else pass_cnt++;
`else
    chk_cnt++; if (hero_x_pos !== 12'd62) $display("FAIL edge_hold_x: got %0d expected 62", hero_x_pos); else pass_cnt++;
`endif
    chk_cnt++; if (moving !== 1'b0) $display("FAIL edge_moving: got %0b expected 0", moving); else pass_cnt++;
    tick(5);
    chk_cnt++; if (moving !== 1'b0) $display("FAIL edge_moving_later: got %0b expected 0", moving); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    collision = 4'd0;
    #3;
    test_reset();
    test_move_up();
    test_blocked_up();
    test_down_limit();
    test_priority_left();
    test_left_edge();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hero_move.md
HERO_MOVE -- requirements
Module: hero_move

Interface
REQ-001 Parameter START_X, default 12'd482, hero x position after reset (tile column 7).
REQ-002 Parameter START_Y, default 12'd648, hero y position after reset (tile row 9).
REQ-003 Parameter STEP_DIV, default 16'd50000, clock cycles per 1-pixel step; legal range 1..65535.
REQ-004 Parameter SCAN_LEN, default 8'd150, cycles per collision scan; equals the wall's full 15x10 block sweep.
REQ-005 Parameter X_MIN 12'd62, X_MAX 12'd902, Y_MIN 12'd108, Y_MAX 12'd648; legal hero top-left limits, 60-px tile grid.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 key_left, key_right, key_up, key_down  input  1 each  level move requests, synchronous to clk.
REQ-009 collision  input  4  wall verdict: 0 none, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN; other codes are treated as 0.
REQ-010 hero_x_pos  output  12  registered hero top-left x; feeds the wall.
REQ-011 hero_y_pos  output  12  registered hero top-left y; feeds the wall.
REQ-012 moving  output  1  high while in MOVE.
REQ-013 dir  output  2  last requested direction: 0 left, 1 right, 2 up, 3 down.

Function
REQ-014 FSM states: SCAN, IDLE, MOVE. Reset enters SCAN.
REQ-015 SCAN: blocked[3:0] is cleared on entry. Each cycle, collision code n (1..4) sets blocked[n-1]. After exactly SCAN_LEN cycles, go to IDLE.
REQ-016 IDLE: with no key high, stay in IDLE and hold blocked.
REQ-017 IDLE key priority is left > right > up > down. dir takes the chosen key on the same edge.
REQ-018 A move is refused when its blocked bit is set. It is also refused when it would leave the limits: left at X_MIN, right at X_MAX, up at Y_MIN, down at Y_MAX.
REQ-019 On a refused move, stay in IDLE. dir still updates. Position is unchanged.
REQ-020 On an accepted move, go to MOVE on the next edge. Clear the step divider and the pixel counter on entry.
REQ-021 MOVE: the step divider counts 0..STEP_DIV-1. On the terminal count, position changes by 1 px in dir and the pixel counter increments.
REQ-022 The first pixel change occurs STEP_DIV cycles after entering MOVE.
REQ-023 After the 60th step, the tile is complete and the state goes to SCAN on that same edge. A one-tile move takes 60*STEP_DIV cycles.
REQ-024 Key inputs are ignored in MOVE and SCAN. Collision input is ignored outside SCAN.
REQ-025 Positions are 12-bit unsigned; arithmetic never wraps because the limits are checked before a move starts.
REQ-026 moving = (state==MOVE); it is registered, with no combinational path from the inputs.

Reset
REQ-027 While rst is low, asynchronously set: state=SCAN, hero_x_pos=START_X, hero_y_pos=START_Y, moving=0, dir=0, blocked=0, divider=0, pixel counter=0, scan counter=0.
REQ-028 Reset asserted mid-MOVE abandons the move; position returns to START_X/START_Y immediately.
REQ-029 After rst deasserts, the first edge begins a full SCAN_LEN-cycle scan.

Configuration
REQ-030 Macro HERO_WRAP_EN.
- Defined: in IDLE, a left request at X_MIN with blocked[0]=0 sets hero_x_pos=X_MAX in one edge, then enters SCAN with no MOVE. A right request at X_MAX with blocked[1]=0 sets X_MIN the same way.
- Undefined: horizontal edge moves are refused per REQ-018.
- Vertical limits never wrap in either build.

Verification
REQ-031 Bench uses STEP_DIV=2 and SCAN_LEN=150.
- rst low mid-run -> outputs are 482/648, moving=0, state SCAN immediately.
- After release, 150 cycles later state is IDLE.
REQ-032 Hold key_up with collision=0 through the scan.
- moving rises the edge after IDLE is reached.
- y steps 648->647 two cycles later.
- After 120 cycles, y=588 and the state is SCAN.
REQ-033 Pulse collision=3 for one cycle during the scan, then hold key_up in IDLE -> dir=2, moving stays 0, y stays 648.
REQ-034 Hold key_down at y=648 (Y_MAX) -> move refused, dir=3, position unchanged.
REQ-035 Hold key_left and key_up together at 482/648 -> left wins, x reaches 422 and y stays 648.
REQ-036 HERO_WRAP_EN build: x at 62, key_left held, no collision -> x=902 in one edge, moving never asserts. Non-wrap build: x stays 62.
